// File: rtl/tone_bank.sv
// Multi-voice square-wave tone generator. Each voice has a host-written shadow register and a
// period-locked active copy. Voice outputs are summed and fed to a first-order sigma-delta bit.
module tone_bank #(
  parameter int NUM_VOICES = 4,
  parameter int PERIOD_W   = 16
) (
  input  logic                                  CLK,
  input  logic                                  RST_N,
  input  logic                                  WR_EN,
  input  logic [3:0]                            WR_ADDR,
  input  logic [PERIOD_W+2:0]                   WR_DATA,
  input  logic                                  SYNC,
  output logic [NUM_VOICES-1:0]                 VOICE_OUT,
  output logic [$clog2(NUM_VOICES+1)-1:0]       AUDIO_SUM,
  output logic                                  AUDIO
);

  localparam int SW = $clog2(NUM_VOICES + 1);
  localparam int AW = $clog2(2 * NUM_VOICES);
  localparam logic [PERIOD_W-1:0] P_ONE = PERIOD_W'(1);

  function automatic logic [PERIOD_W-1:0] calc_thr(input logic [1:0] duty,
                                                   input logic [PERIOD_W-1:0] p);
    case (duty)
      2'd0:    return p >> 1;
      2'd1:    return p >> 2;
      2'd2:    return p >> 3;
      default: return p - (p >> 2);
    endcase
  endfunction

  function automatic logic [SW-1:0] popcount(input logic [NUM_VOICES-1:0] v);
    logic [SW-1:0] n;
    n = '0;
    for (int k = 0; k < NUM_VOICES; k++) n = n + SW'(v[k]);
    return n;
  endfunction

  logic [NUM_VOICES-1:0]               sh_en_q, sh_en_d;
  logic [NUM_VOICES-1:0][1:0]          sh_duty_q, sh_duty_d;
  logic [NUM_VOICES-1:0][PERIOD_W-1:0] sh_p_q, sh_p_d;
  logic [NUM_VOICES-1:0][PERIOD_W-1:0] act_p_q, act_p_d;
  logic [NUM_VOICES-1:0][PERIOD_W-1:0] thr_q, thr_d;
  logic [NUM_VOICES-1:0][PERIOD_W-1:0] cnt_q, cnt_d;
  logic [NUM_VOICES-1:0]               run_q, run_d;
  logic [NUM_VOICES-1:0]               valid_w;
  logic [NUM_VOICES-1:0]               vout_d;
  logic [AW-1:0]                       acc_q, acc_d;
  logic                                audio_d;
  logic [AW:0]                         sd_t;

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      valid_w[i] = sh_en_q[i] && (sh_p_q[i] > P_ONE);
    end
  end

  // Reload only at period boundaries (idle, wrap or SYNC) and always from the pre-write shadow.
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      sh_en_d[i]   = sh_en_q[i];
      sh_duty_d[i] = sh_duty_q[i];
      sh_p_d[i]    = sh_p_q[i];
      run_d[i]     = run_q[i];
      cnt_d[i]     = cnt_q[i];
      act_p_d[i]   = act_p_q[i];
      thr_d[i]     = thr_q[i];
      if (SYNC || !run_q[i] || (cnt_q[i] == act_p_q[i] - P_ONE)) begin
        cnt_d[i] = '0;
        run_d[i] = valid_w[i];
        if (valid_w[i]) begin
          act_p_d[i] = sh_p_q[i];
          thr_d[i]   = calc_thr(sh_duty_q[i], sh_p_q[i]);
        end
      end else begin
        cnt_d[i] = cnt_q[i] + P_ONE;
      end
      if (WR_EN && (WR_ADDR == 4'(i))) begin
        sh_en_d[i]   = WR_DATA[PERIOD_W+2];
        sh_duty_d[i] = WR_DATA[PERIOD_W+1:PERIOD_W];
        sh_p_d[i]    = WR_DATA[PERIOD_W-1:0];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      vout_d[i] = run_d[i] && (cnt_d[i] < thr_d[i]);
    end
  end

  always_comb begin
    sd_t    = {1'b0, acc_q} + (AW+1)'(AUDIO_SUM);
    audio_d = 1'b0;
    acc_d   = sd_t[AW-1:0];
    if (sd_t >= (AW+1)'(NUM_VOICES)) begin
      audio_d = 1'b1;
      acc_d   = AW'(sd_t - (AW+1)'(NUM_VOICES));
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sh_en_q   <= '0;
      sh_duty_q <= '0;
      sh_p_q    <= '0;
      act_p_q   <= '0;
      thr_q     <= '0;
      cnt_q     <= '0;
      run_q     <= '0;
      VOICE_OUT <= '0;
      AUDIO_SUM <= '0;
      AUDIO     <= 1'b0;
      acc_q     <= '0;
    end else begin
      sh_en_q   <= sh_en_d;
      sh_duty_q <= sh_duty_d;
      sh_p_q    <= sh_p_d;
      act_p_q   <= act_p_d;
      thr_q     <= thr_d;
      cnt_q     <= cnt_d;
      run_q     <= run_d;
      VOICE_OUT <= vout_d;
      AUDIO_SUM <= popcount(VOICE_OUT);
      AUDIO     <= audio_d;
      acc_q     <= acc_d;
    end
  end

endmodule

// File: tb/tb_tone_bank.sv
// Bench for tone_bank: directed scenarios plus random writes, checked against a timestamp-based
// reference model of each voice's period start, length and high time.
module tb_tone_bank;
  localparam int N  = 4;
  localparam int PW = 16;

  logic          CLK;
  logic          RST_N;
  logic          WR_EN;
  logic [3:0]    WR_ADDR;
  logic [PW+2:0] WR_DATA;
  logic          SYNC;
  logic [N-1:0]  VOICE_OUT;
  logic [2:0]    AUDIO_SUM;
  logic          AUDIO;

  tone_bank #(.NUM_VOICES(N), .PERIOD_W(PW)) dut (
    .CLK(CLK), .RST_N(RST_N), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .SYNC(SYNC), .VOICE_OUT(VOICE_OUT), .AUDIO_SUM(AUDIO_SUM), .AUDIO(AUDIO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: each voice remembers the edge its current period began.
  bit     m_en[N];
  int     m_duty[N];
  int     m_p[N];
  bit     m_run[N];
  longint m_start[N];
  int     m_plen[N];
  int     m_high[N];
  longint edge_n;
  bit [N-1:0] m_vout;
  int     m_sum;
  int     m_acc;
  bit     m_audio;

  function automatic int high_of(input int duty, input int p);
    case (duty)
      0: return p / 2;
      1: return p / 4;
      2: return p / 8;
      default: return p - p / 4;
    endcase
  endfunction

  function automatic logic [PW+2:0] mkw(input bit en, input int duty, input int p);
    logic [PW+2:0] w;
    w = {en, 2'(duty), 16'(p)};
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_en[i] = 0; m_duty[i] = 0; m_p[i] = 0; m_run[i] = 0;
      m_start[i] = 0; m_plen[i] = 0; m_high[i] = 0;
    end
    edge_n = 0; m_vout = '0; m_sum = 0; m_acc = 0; m_audio = 0;
  endtask

  task automatic model_edge();
    int t;
    int ones;
    edge_n++;
    t = m_acc + m_sum;
    if (t >= N) begin m_audio = 1; m_acc = t - N; end
    else begin m_audio = 0; m_acc = t; end
    ones = 0;
    for (int i = 0; i < N; i++) ones += int'(m_vout[i]);
    m_sum = ones;
    for (int i = 0; i < N; i++) begin
      if (SYNC || !m_run[i] || (edge_n - m_start[i] == longint'(m_plen[i]))) begin
        m_start[i] = edge_n;
        m_run[i]   = m_en[i] && (m_p[i] >= 2);
        if (m_run[i]) begin
          m_plen[i] = m_p[i];
          m_high[i] = high_of(m_duty[i], m_p[i]);
        end
      end
      if (WR_EN && (int'(WR_ADDR) == i)) begin
        m_en[i]   = WR_DATA[PW+2];
        m_duty[i] = int'(WR_DATA[PW+1:PW]);
        m_p[i]    = int'(WR_DATA[PW-1:0]);
      end
      m_vout[i] = m_run[i] && ((edge_n - m_start[i]) < longint'(m_high[i]));
    end
  endtask

  task automatic check_outputs(input string tag);
    total++;
    assert (VOICE_OUT === m_vout) else begin
      bad++; $error("FAIL %s vout t=%0t got=%b exp=%b", tag, $time, VOICE_OUT, m_vout);
    end
    total++;
    assert (AUDIO_SUM === 3'(m_sum)) else begin
      bad++; $error("FAIL %s sum t=%0t got=%0d exp=%0d", tag, $time, AUDIO_SUM, m_sum);
    end
    total++;
    assert (AUDIO === m_audio) else begin
      bad++; $error("FAIL %s audio t=%0t got=%b exp=%b", tag, $time, AUDIO, m_audio);
    end
  endtask

  task automatic check_zero(input string tag);
    total++;
    assert ((VOICE_OUT === '0) && (AUDIO_SUM === 3'd0) && (AUDIO === 1'b0)) else begin
      bad++; $error("FAIL %s got vout=%b sum=%0d audio=%b exp all 0", tag, VOICE_OUT, AUDIO_SUM, AUDIO);
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++; $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic step(input bit we, input int addr, input logic [PW+2:0] data, input bit sy,
                      input string tag);
    WR_EN = we; WR_ADDR = 4'(addr); WR_DATA = data; SYNC = sy;
    @(posedge CLK);
    model_edge();
    #1;
    check_outputs(tag);
    WR_EN = 0; SYNC = 0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) step(0, 0, '0, 0, tag);
  endtask

  task automatic reset_mid(input string tag);
    #3 RST_N = 0;
    #1 check_zero(tag);
    model_reset();
    @(posedge CLK);
    #1 check_zero(tag);
    RST_N = 1;
  endtask

  initial begin
    RST_N = 0; WR_EN = 0; WR_ADDR = '0; WR_DATA = '0; SYNC = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1 check_zero("reset");
    RST_N = 1;
    idle(5, "post_reset");
    check_zero("idle_after_reset");

    // Voice 0: 50% duty, P=10
    step(1, 0, mkw(1, 0, 10), 0, "v0_write");
    check_bit("v0_low_at_write", VOICE_OUT[0], 1'b0);
    step(0, 0, '0, 0, "v0_start");
    check_bit("v0_high_first", VOICE_OUT[0], 1'b1);
    idle(25, "v0_run");

    // Voice 1 duty variants
    step(1, 1, mkw(1, 1, 8), 0, "v1_d1");
    idle(20, "v1_d1_run");
    step(1, 1, mkw(1, 3, 8), 0, "v1_d3");
    idle(20, "v1_d3_run");
    step(1, 1, mkw(1, 2, 16), 0, "v1_d2");
    idle(40, "v1_d2_run");

    // Voice 0 rewrites mid-period, disable, then invalid period
    step(1, 0, mkw(1, 0, 20), 0, "v0_p20");
    idle(50, "v0_p20_run");
    step(1, 0, mkw(0, 0, 20), 0, "v0_dis");
    idle(30, "v0_dis_run");
    step(1, 0, mkw(1, 0, 1), 0, "v0_p1");
    idle(20, "v0_p1_run");
    check_bit("v0_p1_idle", VOICE_OUT[0], 1'b0);

    // All voices P=4, aligned by SYNC
    for (int v = 0; v < N; v++) step(1, v, mkw(1, 0, 4), 0, "all_p4");
    idle(3, "all_p4_pre");
    step(0, 0, '0, 1, "sync");
    idle(16, "sync_run");
    check_bit("sync_aligned", VOICE_OUT[0] ^ VOICE_OUT[3], 1'b0);

    // Half the voices steady high (75% of long period), half off
    step(1, 2, mkw(0, 0, 4), 0, "v2_off");
    step(1, 3, mkw(0, 0, 4), 0, "v3_off");
    step(1, 0, mkw(1, 3, 400), 0, "v0_long");
    step(1, 1, mkw(1, 3, 400), 0, "v1_long");
    step(0, 0, '0, 1, "sync2");
    idle(60, "density");

    // Write landing exactly on a wrap edge
    step(1, 0, mkw(1, 0, 10), 0, "wrap_setup");
    step(0, 0, '0, 1, "wrap_sync");
    idle(9, "wrap_pre");
    step(1, 0, mkw(1, 1, 6), 0, "wrap_write");
    idle(25, "wrap_post");

    // Out-of-range address and write coinciding with SYNC
    step(1, N, mkw(1, 3, 5), 0, "bad_addr");
    idle(10, "bad_addr_run");
    step(1, 2, mkw(1, 0, 6), 1, "write_sync");
    idle(20, "write_sync_run");

    reset_mid("reset_mid");
    idle(10, "reset_after");
    check_zero("reset_stays_idle");

    // Random phase
    for (int k = 0; k < 1500; k++) begin
      bit we, sy, en;
      int addr, duty, p;
      we   = ($urandom_range(0, 3) == 0);
      addr = $urandom_range(0, 5);
      en   = ($urandom_range(0, 7) != 0);
      duty = $urandom_range(0, 3);
      p    = $urandom_range(0, 24);
      sy   = ($urandom_range(0, 49) == 0);
      step(we, addr, mkw(en, duty, p), sy, "random");
      if (k == 700) reset_mid("random_reset");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tone_bank.md
# tone_bank

Multi-voice square-wave tone generator: NUM_VOICES independent programmable-period oscillators with selectable duty cycle and glitch-free parameter updates, summed and converted to a 1-bit first-order sigma-delta stream. It sits between the note/sequencer control logic (register writes) and the audio output pin, and supersedes the single fixed-table oscillator.

## Interface
- NUM_VOICES, 4, number of voices (1..16)
- PERIOD_W, 16, period counter width in bits
- CLK  input  1  clock
- RST_N  input  1  reset; asynchronous, active-low
- WR_EN  input  1  write strobe for voice shadow register
- WR_ADDR  input  4  voice index; values >= NUM_VOICES ignored
- WR_DATA  input  PERIOD_W+3  bit [PERIOD_W+2] enable, [PERIOD_W+1:PERIOD_W] duty code, [PERIOD_W-1:0] period P in CLK cycles
- SYNC  input  1  restart all voices in phase at next edge
- VOICE_OUT  output  NUM_VOICES  per-voice square wave, registered
- AUDIO_SUM  output  $clog2(NUM_VOICES+1)  registered count of high voices
- AUDIO  output  1  sigma-delta output, registered

## Operation
- Per voice: shadow register {en, duty, P} (written by host) and active register {duty, P, thr} (used by counter); counter cnt [PERIOD_W-1:0]; state IDLE/RUN.
- Voice valid when shadow en=1 and P>=2; P=0/1 treated as disabled.
- Threshold from active P: duty 0 -> P>>1 (50%), 1 -> P>>2 (25%), 2 -> P>>3 (12.5%), 3 -> P-(P>>2) (75%). thr computed at load time, stored.
- VOICE_OUT[i]=1 exactly in cycles where voice is RUN and cnt<thr; else 0. Registered, no combinational path from inputs.
- IDLE: cnt=0, output 0. Each edge: if shadow valid, load active, cnt<=0, -> RUN.
- RUN: cnt<=cnt+1 each edge. At edge where cnt==P_active-1 (wrap): cnt<=0, reload active from shadow; if shadow not valid -> IDLE. Parameters never change mid-period: no runt pulses.
- SYNC=1 at an edge: every voice behaves as if at wrap (cnt<=0, reload from shadow, RUN or IDLE per validity).
- AUDIO_SUM: popcount of VOICE_OUT, registered.
- Sigma-delta: accumulator acc, width $clog2(2*NUM_VOICES); t=acc+AUDIO_SUM; if t>=NUM_VOICES then AUDIO<=1, acc<=t-NUM_VOICES else AUDIO<=0, acc<=t. Long-run density of AUDIO = AUDIO_SUM/NUM_VOICES.
- Reset: all shadows cleared (disabled, P=0, duty 0), all voices IDLE, cnt=0, acc=0, VOICE_OUT=0, AUDIO_SUM=0, AUDIO=0. Reset mid-period aborts immediately; no completion of the period.

## Timing
- Write sampled at edge t updates shadow at edge t.
- IDLE voice: written valid at edge t -> RUN at edge t+1; VOICE_OUT high in cycle after t+1 (cnt=0 < thr) for thr cycles, then low for P-thr cycles.
- Write and wrap on same voice at same edge: wrap loads OLD shadow; new value applies at following wrap.
- Write and SYNC at same edge: SYNC loads OLD shadow.
- Disable while RUN: current period completes in full, voice IDLE at wrap edge.
- Period exactly P cycles; high time exactly thr cycles.
- AUDIO_SUM lags VOICE_OUT by 1 cycle; AUDIO lags AUDIO_SUM by 1 cycle.
- Writes to WR_ADDR>=NUM_VOICES: no state change.

## Test plan
- Reset: assert RST_N low mid-run -> all outputs 0 immediately; after release all voices IDLE, AUDIO=0 indefinitely.
- Voice 0 write en=1, duty 0, P=10 -> VOICE_OUT[0] 5 high / 5 low repeating, starting 2 edges after write; AUDIO_SUM toggles 1/0 one cycle later.
- Voice 1 P=8 duty 1 -> 2 high / 6 low; duty 3 -> 6 high / 2 low; duty 2 P=16 -> 2 high / 14 low.
- Voice 0 running P=10, rewrite P=20 at cnt=3 -> current period stays 10 cycles, next periods 20 (10 high/10 low); rewrite en=0 mid-period -> period completes, then 0; write P=1 -> voice stays IDLE.
- All 4 voices P=4 duty 0, then SYNC -> all VOICE_OUT aligned, AUDIO_SUM alternates 4/0, AUDIO alternates 1/0; 2 of 4 voices steady-high-phase -> AUDIO density 50% over window.
- Simultaneous write and wrap on same voice -> old parameters for next period, new ones after; write to WR_ADDR=NUM_VOICES -> no effect on any voice.
